// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               PCEn;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [3:0]         ALUControl;
  logic [1:0]         PCSrc;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero, mem_ready,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, dbg_state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, dbg_state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC <= PC+4, wait for memory
//  DECODE | read registers, precompute branch target, dispatch on op
//  MEMADR | ALUOut <= A + SignImm (lw/sw address)
//  MEMRD  | read data memory at ALUOut, wait for memory
//  MEMWB  | rt <= Data
//  MEMWR  | write data memory at ALUOut, hold strobe until memory accepts
//  EXEC   | R-type ALU operation on A, B
//  ALUWB  | rd <= ALUOut
//  BEQ    | compare A, B; branch to ALUOut when equal
//  ADDIEX | ALUOut <= A + SignImm
//  ADDIWB | rt <= ALUOut
//  JUMP   | PC <= jump target
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 'd0,
    S_DECODE = 'd1,
    S_MEMADR = 'd2,
    S_MEMRD  = 'd3,
    S_MEMWB  = 'd4,
    S_MEMWR  = 'd5,
    S_EXEC   = 'd6,
    S_ALUWB  = 'd7,
    S_BEQ    = 'd8,
    S_ADDIEX = 'd9,
    S_ADDIWB = 'd10,
    S_JUMP   = 'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ready;
  logic       w_funct_ok;
  logic [3:0] w_funct_alu;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_mem_ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // R-type funct decode; unknown functs fall back to add (already flagged in DECODE).
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  // Next-state and state-decoded controls.
  always_comb begin
    w_next         = S_FETCH;
    w_pc_write     = 1'b0;
    w_branch       = 1'b0;
    w_irwrite      = 1'b0;
    w_memwrite     = 1'b0;
    w_regwrite     = 1'b0;
    w_illegal      = 1'b0;
    bus.IorD       = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 4'b0000;
    bus.PCSrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = ALU_ADD;
        w_irwrite      = w_mem_ready;
        w_pc_write     = w_mem_ready;
        w_next         = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.ALUControl = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            w_next    = S_EXEC;
            w_illegal = ~w_funct_ok;
          end
          OP_BEQ:  w_next = S_BEQ;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = ALU_ADD;
        if (r_state == S_ADDIEX) w_next = S_ADDIWB;
        else                     w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD = 1'b1;
        w_next   = w_mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        w_regwrite   = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD   = 1'b1;
        w_memwrite = 1'b1;
        w_next     = w_mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = w_funct_alu;
        w_next         = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_SUB;
        bus.PCSrc      = 2'b01;
        w_branch       = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        bus.PCSrc  = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are killed during reset so an abandoned instruction writes nothing.
  always_comb begin
    bus.PCEn     = ~rst & (w_pc_write | (w_branch & bus.zero));
    bus.IRWrite  = ~rst & w_irwrite;
    bus.MemWrite = ~rst & w_memwrite;
    bus.RegWrite = ~rst & w_regwrite;
    bus.illegal  = ~rst & w_illegal;
  end

  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl with a per-cycle expectation scoreboard.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

  multicycle_ctrl #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: PCEn IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA |
  //               ALUSrcB[1:0] | ALUControl[3:0] | PCSrc[1:0] | illegal
  localparam logic [16:0] E_FETCH_R   = 17'b1001_0000_01_0010_00_0;
  localparam logic [16:0] E_FETCH_W   = 17'b0000_0000_01_0010_00_0;
  localparam logic [16:0] E_DEC       = 17'b0000_0000_11_0010_00_0;
  localparam logic [16:0] E_DEC_ILL   = 17'b0000_0000_11_0010_00_1;
  localparam logic [16:0] E_ADR       = 17'b0000_0001_10_0010_00_0;
  localparam logic [16:0] E_MEMRD     = 17'b0100_0000_00_0000_00_0;
  localparam logic [16:0] E_MEMWB     = 17'b0000_0110_00_0000_00_0;
  localparam logic [16:0] E_MEMWB_RST = 17'b0000_0100_00_0000_00_0;
  localparam logic [16:0] E_MEMWR     = 17'b0110_0000_00_0000_00_0;
  localparam logic [16:0] E_MEMWR_RST = 17'b0100_0000_00_0000_00_0;
  localparam logic [16:0] E_EX_ADD    = 17'b0000_0001_00_0010_00_0;
  localparam logic [16:0] E_EX_SUB    = 17'b0000_0001_00_0110_00_0;
  localparam logic [16:0] E_EX_AND    = 17'b0000_0001_00_0000_00_0;
  localparam logic [16:0] E_EX_OR     = 17'b0000_0001_00_0001_00_0;
  localparam logic [16:0] E_EX_SLT    = 17'b0000_0001_00_0111_00_0;
  localparam logic [16:0] E_ALUWB     = 17'b0000_1010_00_0000_00_0;
  localparam logic [16:0] E_ALUWB_RST = 17'b0000_1000_00_0000_00_0;
  localparam logic [16:0] E_ADDIWB    = 17'b0000_0010_00_0000_00_0;
  localparam logic [16:0] E_BEQ_T     = 17'b1000_0001_00_0110_01_0;
  localparam logic [16:0] E_BEQ_F     = 17'b0000_0001_00_0110_01_0;
  localparam logic [16:0] E_JUMP      = 17'b1000_0000_00_0000_10_0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_BAD   = 6'b111000;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Apply one cycle of inputs and record what the DUT must show during it.
  task automatic cyc(input string tag, input logic r, input logic [5:0] o,
                     input logic [5:0] f, input logic z, input logic m,
                     input logic [3:0] st, input logic [16:0] ctl);
    exp_t e;
    rst           = r;
    bus.op        = o;
    bus.funct     = f;
    bus.zero      = z;
    bus.mem_ready = m;
    e.tag = tag;
    e.st  = st;
    e.ctl = ctl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    exp_t        e;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
               bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
               bus.ALUControl, bus.PCSrc, bus.illegal};
        n_cmp++;
        if (act !== e.ctl || bus.dbg_state !== e.st) begin
          n_err++;
          $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   e.tag, bus.dbg_state, act, e.st, e.ctl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  fn [4];
    logic [16:0] ex [4];
    fn[0] = F_SUB; ex[0] = E_EX_SUB;
    fn[1] = F_AND; ex[1] = E_EX_AND;
    fn[2] = F_OR;  ex[2] = E_EX_OR;
    fn[3] = F_SLT; ex[3] = E_EX_SLT;

    rst = 1'b1; bus.op = OP_R; bus.funct = F_ADD; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;

    // reset holds FETCH with strobes off even though mem_ready=1
    cyc("rst0", 1, OP_R, F_ADD, 0, 1, 0, E_FETCH_W);
    cyc("rst1", 1, OP_R, F_ADD, 0, 1, 0, E_FETCH_W);

    // R-type add; mem_ready low outside FETCH must be ignored
    cyc("add_fetch",  0, OP_R, F_ADD, 0, 1, 0, E_FETCH_R);
    cyc("add_decode", 0, OP_R, F_ADD, 0, 0, 1, E_DEC);
    cyc("add_exec",   0, OP_R, F_ADD, 0, 0, 6, E_EX_ADD);
    cyc("add_aluwb",  0, OP_R, F_ADD, 0, 0, 7, E_ALUWB);

    for (int i = 0; i < 4; i++) begin
      cyc("r_fetch",  0, OP_R, fn[i], 0, 1, 0, E_FETCH_R);
      cyc("r_decode", 0, OP_R, fn[i], 0, 1, 1, E_DEC);
      cyc("r_exec",   0, OP_R, fn[i], 0, 1, 6, ex[i]);
      cyc("r_aluwb",  0, OP_R, fn[i], 0, 1, 7, E_ALUWB);
    end

    // unsupported funct: flagged in DECODE, executes as add
    cyc("badf_fetch",  0, OP_R, F_BAD, 0, 1, 0, E_FETCH_R);
    cyc("badf_decode", 0, OP_R, F_BAD, 0, 1, 1, E_DEC_ILL);
    cyc("badf_exec",   0, OP_R, F_BAD, 0, 1, 6, E_EX_ADD);
    cyc("badf_aluwb",  0, OP_R, F_BAD, 0, 1, 7, E_ALUWB);

    // lw with 2 wait cycles in FETCH and 1 in MEMRD
    cyc("lw_fetch_w0", 0, OP_LW, 0, 0, 0, 0, E_FETCH_W);
    cyc("lw_fetch_w1", 0, OP_LW, 0, 0, 0, 0, E_FETCH_W);
    cyc("lw_fetch_r",  0, OP_LW, 0, 0, 1, 0, E_FETCH_R);
    cyc("lw_decode",   0, OP_LW, 0, 0, 1, 1, E_DEC);
    cyc("lw_memadr",   0, OP_LW, 0, 0, 1, 2, E_ADR);
    cyc("lw_memrd_w",  0, OP_LW, 0, 0, 0, 3, E_MEMRD);
    cyc("lw_memrd_r",  0, OP_LW, 0, 0, 1, 3, E_MEMRD);
    cyc("lw_memwb",    0, OP_LW, 0, 0, 1, 4, E_MEMWB);

    // sw with 3 wait cycles in MEMWR: MemWrite held 4 cycles
    cyc("sw_fetch",   0, OP_SW, 0, 0, 1, 0, E_FETCH_R);
    cyc("sw_decode",  0, OP_SW, 0, 0, 1, 1, E_DEC);
    cyc("sw_memadr",  0, OP_SW, 0, 0, 1, 2, E_ADR);
    cyc("sw_memwr_0", 0, OP_SW, 0, 0, 0, 5, E_MEMWR);
    cyc("sw_memwr_1", 0, OP_SW, 0, 0, 0, 5, E_MEMWR);
    cyc("sw_memwr_2", 0, OP_SW, 0, 0, 0, 5, E_MEMWR);
    cyc("sw_memwr_3", 0, OP_SW, 0, 0, 1, 5, E_MEMWR);

    // beq taken, then not taken (zero high in DECODE must not matter)
    cyc("beqt_fetch",  0, OP_BEQ, 0, 1, 1, 0, E_FETCH_R);
    cyc("beqt_decode", 0, OP_BEQ, 0, 1, 1, 1, E_DEC);
    cyc("beqt_beq",    0, OP_BEQ, 0, 1, 1, 8, E_BEQ_T);
    cyc("beqf_fetch",  0, OP_BEQ, 0, 0, 1, 0, E_FETCH_R);
    cyc("beqf_decode", 0, OP_BEQ, 0, 1, 1, 1, E_DEC);
    cyc("beqf_beq",    0, OP_BEQ, 0, 0, 1, 8, E_BEQ_F);

    cyc("addi_fetch",  0, OP_ADDI, 0, 0, 1, 0,  E_FETCH_R);
    cyc("addi_decode", 0, OP_ADDI, 0, 0, 1, 1,  E_DEC);
    cyc("addi_ex",     0, OP_ADDI, 0, 0, 1, 9,  E_ADR);
    cyc("addi_wb",     0, OP_ADDI, 0, 0, 1, 10, E_ADDIWB);

    cyc("j_fetch",  0, OP_J, 0, 0, 1, 0,  E_FETCH_R);
    cyc("j_decode", 0, OP_J, 0, 0, 1, 1,  E_DEC);
    cyc("j_jump",   0, OP_J, 0, 0, 1, 11, E_JUMP);

    // unsupported opcode: illegal pulse, straight back to FETCH
    cyc("ill_fetch",  0, OP_BAD, 0, 0, 1, 0, E_FETCH_R);
    cyc("ill_decode", 0, OP_BAD, 0, 0, 1, 1, E_DEC_ILL);
    cyc("ill_after",  0, OP_BAD, 0, 0, 0, 0, E_FETCH_W);

    // reset in ALUWB suppresses the write
    cyc("ra_fetch",  0, OP_R, F_ADD, 0, 1, 0, E_FETCH_R);
    cyc("ra_decode", 0, OP_R, F_ADD, 0, 1, 1, E_DEC);
    cyc("ra_exec",   0, OP_R, F_ADD, 0, 1, 6, E_EX_ADD);
    cyc("ra_aluwb",  1, OP_R, F_ADD, 0, 1, 7, E_ALUWB_RST);
    cyc("ra_after",  0, OP_R, F_ADD, 0, 0, 0, E_FETCH_W);

    // reset in MEMWB suppresses the write
    cyc("rm_fetch",  0, OP_LW, 0, 0, 1, 0, E_FETCH_R);
    cyc("rm_decode", 0, OP_LW, 0, 0, 1, 1, E_DEC);
    cyc("rm_memadr", 0, OP_LW, 0, 0, 1, 2, E_ADR);
    cyc("rm_memrd",  0, OP_LW, 0, 0, 1, 3, E_MEMRD);
    cyc("rm_memwb",  1, OP_LW, 0, 0, 1, 4, E_MEMWB_RST);
    cyc("rm_after",  0, OP_LW, 0, 0, 0, 0, E_FETCH_W);

    // reset in MEMWR suppresses the memory write
    cyc("rw_fetch",  0, OP_SW, 0, 0, 1, 0, E_FETCH_R);
    cyc("rw_decode", 0, OP_SW, 0, 0, 1, 1, E_DEC);
    cyc("rw_memadr", 0, OP_SW, 0, 0, 1, 2, E_ADR);
    cyc("rw_memwr",  1, OP_SW, 0, 0, 0, 5, E_MEMWR_RST);
    cyc("rw_after",  0, OP_SW, 0, 0, 0, 0, E_FETCH_W);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
